sequence_recorder_16x4: RTL and testbench
=========================================

Name: sequence_recorder_16x4

Overview:
- Write-side counterpart of the pre-programmed 16x4 one-hot sequence ROM.
- Captures debounced player button presses (4 buttons, one-hot) into a 16-entry x 4-bit memory, in order.
- Exposes a combinational read port with the same address/data shape as the ROM, so the compare datapath can replay either a fixed sequence or a recorded one.
- Sits between the button inputs and the game datapath; the control unit drives enable/clear and monitors the status pulses.

Parameters:
DEBOUNCE_CYCLES, 4, number of consecutive stable cycles required to accept a press or a release (board top overrides to ~50000)
CNT_W, 16, width of debounce counter; must hold DEBOUNCE_CYCLES

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous clear: count to 0, memory to reset contents, FSM to WAIT_PRESS
enable  input  1  allows new presses to be accepted
botoes  input  4  raw asynchronous buttons, active-high
rd_address  input  4  read address
rd_data  output  4  mem[rd_address], combinational
count  output  5  number of stored entries, 0..16
full  output  1  count == 16
jogada_valida  output  1  1-cycle pulse: one-hot press stored
jogada_invalida  output  1  1-cycle pulse: press rejected (not one-hot, or memory full)
last_jogada  output  4  last accepted value, registered

Behaviour:
- Input path: 2-flop synchronizer on botoes -> bsync; all decisions use bsync only.
- Reset (reset=0, async): FSM=WAIT_PRESS, count=0, full=0, pulses=0, last_jogada=0000, debounce counter=0, synchronizer=0000, all 16 memory words=0000.
- FSM states: WAIT_PRESS, DEBOUNCE_PRESS, CAPTURE, WAIT_RELEASE.
- WAIT_PRESS: if enable=1 and bsync!=0000 -> latch bsync into cand, clear counter, go DEBOUNCE_PRESS; otherwise stay.
- DEBOUNCE_PRESS: if bsync==cand, counter++; when counter reaches DEBOUNCE_CYCLES-1 -> CAPTURE. If bsync!=cand: bsync==0000 -> WAIT_PRESS (glitch); otherwise re-latch cand and restart counter.
- CAPTURE (exactly 1 cycle):
  - cand one-hot and full=0: mem[count[3:0]]<=cand, count++, last_jogada<=cand, jogada_valida=1 in the following cycle.
  - cand not one-hot, or full=1: no write, count unchanged, jogada_invalida=1 in the following cycle.
  - Always -> WAIT_RELEASE.
- WAIT_RELEASE: counter runs while bsync==0000 and resets on any nonzero value; after DEBOUNCE_CYCLES consecutive zero cycles -> WAIT_PRESS. Holding a button therefore never records twice.
- Latency: raw edge to pulse = 2 (sync) + 1 (WAIT_PRESS) + DEBOUNCE_CYCLES + 1 (CAPTURE) cycles.
- enable low: blocks only the WAIT_PRESS exit; a press already in flight completes.
- Wrap: count saturates at 16, and no address wrap occurs. full = count[4].
- clear=1 has priority over every FSM action in the same cycle: no write, no pulse, and the in-flight press is discarded.
- Read port: rd_data = mem[rd_address] combinationally. A same-cycle write becomes visible after the clock edge.
- reset asserted mid-debounce or mid-capture: immediate return to reset values; no partial write.

Optional Feature:
REC_PRELOAD_ROM_EN
- Defined: reset and clear load mem[i] = one-hot(1 << (i mod 4)), i.e. 0001,0010,0100,1000 repeating, and set count=16, full=1. The block then replays the fixed sequence until clear is issued with the macro-defined build… the next capture is rejected as full.
- Undefined: memory resets to 0000 and count=0, as above.

Test Plan:
- Reset, enable=1, press botoes=0010 for 10 cycles then release -> mem[0]=0010, count=1, exactly one jogada_valida pulse, last_jogada=0010.
- Press 0110 held 10 cycles -> jogada_invalida pulse, count unchanged, mem untouched.
- 3-cycle glitch of 0100 with DEBOUNCE_CYCLES=4 -> no pulse, FSM back to WAIT_PRESS, count=0.
- 17 valid presses alternating 0001/1000 -> mem[0..15] correct, full=1 after the 16th, 17th press gives jogada_invalida, count=16.
- Hold 0001 for 40 cycles -> single write, count=1; clear asserted in the CAPTURE cycle of the next press -> count=0, no pulse.
- With REC_PRELOAD_ROM_EN defined: after reset, rd_address=5 -> rd_data=0010, rd_address=15 -> rd_data=1000, full=1.

Source files
------------

// File: rtl/sequence_recorder_16x4.sv
// sequence_recorder_16x4
// Records debounced one-hot button presses into a 16 x 4 memory, in the
// order they are pressed. The combinational read port has the same
// address/data shape as the fixed 16x4 sequence ROM, so the compare datapath
// can replay either source.
// Optional build macro: REC_PRELOAD_ROM_EN. When it is defined, reset and
// clear load the fixed 0001,0010,0100,1000 pattern and mark the memory full.
module sequence_recorder_16x4 #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [3:0] botoes,
    input  logic [3:0] rd_address,
    output logic [3:0] rd_data,
    output logic [4:0] count,
    output logic       full,
    output logic       jogada_valida,
    output logic       jogada_invalida,
    output logic [3:0] last_jogada
);

    typedef enum logic [1:0] {
        WAIT_PRESS     = 2'd0,
        DEBOUNCE_PRESS = 2'd1,
        CAPTURE        = 2'd2,
        WAIT_RELEASE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef REC_PRELOAD_ROM_EN
    // Word i holds one-hot(1 << (i mod 4)); word 0 sits in the low nibble.
    localparam logic [63:0] INIT_IMAGE = 64'h8421_8421_8421_8421;
    localparam logic [4:0]  COUNT_INIT = 5'd16;
`else
    localparam logic [63:0] INIT_IMAGE = 64'h0000_0000_0000_0000;
    localparam logic [4:0]  COUNT_INIT = 5'd0;
`endif

    // A press is only stored when exactly one button is down.
    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    state_t           state_r;
    logic [3:0]       sync1_r;
    logic [3:0]       bsync_r;
    logic [3:0]       cand_r;
    logic [CNT_W-1:0] dbcnt_r;
    logic [4:0]       count_r;
    logic             valida_r;
    logic             invalida_r;
    logic [3:0]       last_r;
    logic [3:0]       mem_r [16];
    logic             wr_en_s;

    // Two-flop synchronizer; every later decision looks at bsync_r only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 4'b0000;
            bsync_r <= 4'b0000;
        end else begin
            sync1_r <= botoes;
            bsync_r <= sync1_r;
        end
    end

    // Store strobe: capturing a one-hot candidate with room left and no clear.
    always_comb begin
        wr_en_s = 1'b0;
        if ((state_r == CAPTURE) && !clear && is_onehot(cand_r) && !count_r[4]) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Press/release debounce FSM with entry count, status pulses and last value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= WAIT_PRESS;
            cand_r     <= 4'b0000;
            dbcnt_r    <= '0;
            count_r    <= COUNT_INIT;
            valida_r   <= 1'b0;
            invalida_r <= 1'b0;
            last_r     <= 4'b0000;
        end else if (clear) begin
            state_r    <= WAIT_PRESS;
            cand_r     <= 4'b0000;
            dbcnt_r    <= '0;
            count_r    <= COUNT_INIT;
            valida_r   <= 1'b0;
            invalida_r <= 1'b0;
        end else begin
            valida_r   <= 1'b0;
            invalida_r <= 1'b0;
            case (state_r)
                WAIT_PRESS: begin
                    if (enable && (bsync_r != 4'b0000)) begin
                        cand_r  <= bsync_r;
                        dbcnt_r <= '0;
                        state_r <= DEBOUNCE_PRESS;
                    end
                end
                DEBOUNCE_PRESS: begin
                    if (bsync_r == cand_r) begin
                        if (dbcnt_r == DB_LAST) begin
                            dbcnt_r <= '0;
                            state_r <= CAPTURE;
                        end else begin
                            dbcnt_r <= dbcnt_r + CNT_W'(1);
                        end
                    end else if (bsync_r == 4'b0000) begin
                        // Released before it settled: treat as a glitch.
                        dbcnt_r <= '0;
                        state_r <= WAIT_PRESS;
                    end else begin
                        // Pattern changed while held: restart on the new value.
                        cand_r  <= bsync_r;
                        dbcnt_r <= '0;
                    end
                end
                CAPTURE: begin
                    if (wr_en_s) begin
                        count_r  <= count_r + 5'd1;
                        last_r   <= cand_r;
                        valida_r <= 1'b1;
                    end else begin
                        invalida_r <= 1'b1;
                    end
                    dbcnt_r <= '0;
                    state_r <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    // A held button never re-arms; only a settled release does.
                    if (bsync_r != 4'b0000) begin
                        dbcnt_r <= '0;
                    end else if (dbcnt_r == DB_LAST) begin
                        dbcnt_r <= '0;
                        state_r <= WAIT_PRESS;
                    end else begin
                        dbcnt_r <= dbcnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    dbcnt_r <= '0;
                    state_r <= WAIT_PRESS;
                end
            endcase
        end
    end

    // Sequence memory: reset/clear image, otherwise append at the current count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= INIT_IMAGE[i*4 +: 4];
            end
        end else if (clear) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= INIT_IMAGE[i*4 +: 4];
            end
        end else if (wr_en_s) begin
            mem_r[count_r[3:0]] <= cand_r;
        end
    end

    assign rd_data         = mem_r[rd_address];
    assign count           = count_r;
    assign full            = count_r[4];
    assign jogada_valida   = valida_r;
    assign jogada_invalida = invalida_r;
    assign last_jogada     = last_r;

endmodule

// File: tb/tb_sequence_recorder_16x4.sv
// Directed bench for sequence_recorder_16x4 with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sequence_recorder_16x4;

    logic       clock_r   = 1'b0;
    logic       reset_r   = 1'b0;
    logic       clear_r   = 1'b0;
    logic       enable_r  = 1'b1;
    logic [3:0] botoes_r  = 4'b0000;
    logic [3:0] rd_addr_r = 4'd0;
    logic [3:0] rd_data_s;
    logic [4:0] count_s;
    logic       full_s;
    logic       valid_s;
    logic       invalid_s;
    logic [3:0] last_s;

    int total = 0;
    int bad   = 0;
    int nvalid = 0;
    int ninvalid = 0;
    int v0;
    int i0;

    sequence_recorder_16x4 #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clock           (clock_r),
        .reset           (reset_r),
        .clear           (clear_r),
        .enable          (enable_r),
        .botoes          (botoes_r),
        .rd_address      (rd_addr_r),
        .rd_data         (rd_data_s),
        .count           (count_s),
        .full            (full_s),
        .jogada_valida   (valid_s),
        .jogada_invalida (invalid_s),
        .last_jogada     (last_s)
    );

    always #5 clock_r = ~clock_r;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clock_r) begin
        if (valid_s)   nvalid++;
        if (invalid_s) ninvalid++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [3:0] exp);
        rd_addr_r = addr;
        #1;
        check(tag, {28'd0, rd_data_s}, {28'd0, exp});
    endtask

    task automatic do_reset();
        @(negedge clock_r);
        reset_r  = 1'b0;
        clear_r  = 1'b0;
        enable_r = 1'b1;
        botoes_r = 4'b0000;
        repeat (3) @(negedge clock_r);
        reset_r = 1'b1;
        @(negedge clock_r);
    endtask

    task automatic press(input logic [3:0] val, input int hold, input int rel);
        botoes_r = val;
        repeat (hold) @(negedge clock_r);
        botoes_r = 4'b0000;
        repeat (rel) @(negedge clock_r);
    endtask

    initial begin
        do_reset();
`ifdef REC_PRELOAD_ROM_EN
        check("pre_count", {27'd0, count_s}, 32'd16);
        check("pre_full", {31'd0, full_s}, 32'd1);
        read_check("pre_mem5", 4'd5, 4'b0010);
        read_check("pre_mem15", 4'd15, 4'b1000);
        for (int i = 0; i < 16; i++) begin
            read_check("pre_mem", 4'(i), 4'(4'b0001 << (i % 4)));
        end
        v0 = nvalid; i0 = ninvalid;
        press(4'b0001, 10, 10);
        check("pre_full_rej", ninvalid - i0, 1);
        check("pre_no_valid", nvalid - v0, 0);
        check("pre_count2", {27'd0, count_s}, 32'd16);
`else
        // Reset state
        check("rst_count", {27'd0, count_s}, 32'd0);
        check("rst_full", {31'd0, full_s}, 32'd0);
        check("rst_valid", {31'd0, valid_s}, 32'd0);
        check("rst_invalid", {31'd0, invalid_s}, 32'd0);
        check("rst_last", {28'd0, last_s}, 32'd0);
        read_check("rst_mem0", 4'd0, 4'b0000);
        read_check("rst_mem15", 4'd15, 4'b0000);

        // Valid press with exact latency: 2 sync + 1 + 4 debounce + 1 capture
        v0 = nvalid; i0 = ninvalid;
        botoes_r = 4'b0010;
        repeat (7) @(negedge clock_r);
        check("lat_early", {31'd0, valid_s}, 32'd0);
        @(negedge clock_r);
        check("lat_pulse", {31'd0, valid_s}, 32'd1);
        @(negedge clock_r);
        check("lat_one_cycle", {31'd0, valid_s}, 32'd0);
        @(negedge clock_r);
        botoes_r = 4'b0000;
        repeat (10) @(negedge clock_r);
        check("t1_nvalid", nvalid - v0, 1);
        check("t1_ninvalid", ninvalid - i0, 0);
        check("t1_count", {27'd0, count_s}, 32'd1);
        check("t1_last", {28'd0, last_s}, 32'h2);
        read_check("t1_mem0", 4'd0, 4'b0010);

        // Non-one-hot press is rejected
        v0 = nvalid; i0 = ninvalid;
        press(4'b0110, 10, 10);
        check("t2_ninvalid", ninvalid - i0, 1);
        check("t2_nvalid", nvalid - v0, 0);
        check("t2_count", {27'd0, count_s}, 32'd1);
        check("t2_last", {28'd0, last_s}, 32'h2);
        read_check("t2_mem0", 4'd0, 4'b0010);
        read_check("t2_mem1", 4'd1, 4'b0000);

        // enable low blocks new presses
        enable_r = 1'b0;
        v0 = nvalid; i0 = ninvalid;
        press(4'b0001, 10, 10);
        check("en_nvalid", nvalid - v0, 0);
        check("en_ninvalid", ninvalid - i0, 0);
        check("en_count", {27'd0, count_s}, 32'd1);
        enable_r = 1'b1;

        // Short glitch is ignored, next real press still records
        do_reset();
        v0 = nvalid; i0 = ninvalid;
        press(4'b0100, 3, 10);
        check("gl_nvalid", nvalid - v0, 0);
        check("gl_ninvalid", ninvalid - i0, 0);
        check("gl_count", {27'd0, count_s}, 32'd0);
        press(4'b0100, 10, 10);
        check("gl_after_count", {27'd0, count_s}, 32'd1);
        read_check("gl_after_mem0", 4'd0, 4'b0100);

        // Fill all 16 entries, 17th rejected
        do_reset();
        v0 = nvalid; i0 = ninvalid;
        for (int i = 0; i < 17; i++) begin
            press((i % 2 == 0) ? 4'b0001 : 4'b1000, 10, 10);
            if (i == 14) check("fill_notfull15", {31'd0, full_s}, 32'd0);
            if (i == 15) begin
                check("fill_full16", {31'd0, full_s}, 32'd1);
                check("fill_count16", {27'd0, count_s}, 32'd16);
            end
        end
        check("fill_nvalid", nvalid - v0, 16);
        check("fill_ninvalid", ninvalid - i0, 1);
        check("fill_count", {27'd0, count_s}, 32'd16);
        check("fill_full", {31'd0, full_s}, 32'd1);
        check("fill_last", {28'd0, last_s}, 32'h8);
        for (int i = 0; i < 16; i++) begin
            read_check("fill_mem", 4'(i), (i % 2 == 0) ? 4'b0001 : 4'b1000);
        end

        // Long hold records once; clear in CAPTURE discards the next press
        do_reset();
        v0 = nvalid; i0 = ninvalid;
        press(4'b0001, 40, 10);
        check("hold_nvalid", nvalid - v0, 1);
        check("hold_count", {27'd0, count_s}, 32'd1);
        v0 = nvalid; i0 = ninvalid;
        botoes_r = 4'b1000;
        repeat (7) @(negedge clock_r);
        clear_r = 1'b1;
        @(negedge clock_r);
        clear_r  = 1'b0;
        botoes_r = 4'b0000;
        check("clr_no_pulse", {31'd0, valid_s}, 32'd0);
        check("clr_count", {27'd0, count_s}, 32'd0);
        read_check("clr_mem0", 4'd0, 4'b0000);
        repeat (12) @(negedge clock_r);
        check("clr_nvalid", nvalid - v0, 0);
        check("clr_ninvalid", ninvalid - i0, 0);
        check("clr_count2", {27'd0, count_s}, 32'd0);
        press(4'b1000, 10, 10);
        check("post_clr_count", {27'd0, count_s}, 32'd1);
        read_check("post_clr_mem0", 4'd0, 4'b1000);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
